// File: rtl/gcd_client_pkg.sv
// Shared types and defaults for the GCD initiator wrapper.
package gcd_client_pkg;

   localparam int unsigned GCD_WIDTH       = 32;
   localparam int unsigned GCD_TIMEOUT_CYC = 4096;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESTART = 2'd1,
      WAIT    = 2'd2,
      RESP    = 2'd3
   } gcd_client_state_e;

   typedef struct packed {
      logic [GCD_WIDTH-1:0] gcd;
      logic                 err;
   } gcd_result_t;

endpackage

// File: rtl/gcd_client.sv
// Initiator wrapper that restarts a subtractive GCD core per request and returns its result.
// Optional build macro GCD_TIMEOUT_EN adds a WAIT-state abort counter and the rsp_err flag.
module gcd_client
   import gcd_client_pkg::*;
#(
   parameter int unsigned WIDTH = GCD_WIDTH
`ifdef GCD_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYC = GCD_TIMEOUT_CYC
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_gcd,
   output logic             rsp_err,
   output logic             core_rst_n,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_gcd
);

   gcd_client_state_e state_q, state_d;

   logic             req_ready_d;
   logic             rsp_valid_d;
   logic             core_rst_n_d;
   logic [WIDTH-1:0] rsp_gcd_d;
   logic [WIDTH-1:0] core_a_d;
   logic [WIDTH-1:0] core_b_d;
   logic             done_q, done_d;

   logic             accept;
   logic             rsp_fire;
   logic             done_rise;
   logic             bypass;
   logic [WIDTH-1:0] bypass_gcd;
   logic             wait_expired;

   assign accept    = req_valid && req_ready;
   assign rsp_fire  = rsp_valid && rsp_ready;
   assign done_rise = core_done && !done_q;

   // The core never terminates on a zero operand, so zero and equal pairs are answered locally.
   assign bypass     = (req_a == '0) || (req_b == '0) || (req_a == req_b);
   assign bypass_gcd = (req_a == '0) ? req_b : req_a;

`ifdef GCD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             rsp_err_d;

   // Counter holds the number of WAIT cycles already spent; the last permitted one aborts.
   assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         wait_cnt <= (state_q == WAIT) ? CNT_W'(wait_cnt + 1'b1) : '0;
         rsp_err  <= rsp_err_d;
      end
   end

   always_comb begin
      rsp_err_d = rsp_err;
      if ((state_q == IDLE) && accept) begin
         rsp_err_d = 1'b0;
      end else if ((state_q == WAIT) && !done_rise && wait_expired) begin
         rsp_err_d = 1'b1;
      end
   end
`else
   assign wait_expired = 1'b0;
   assign rsp_err      = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_gcd    <= '0;
         core_rst_n <= 1'b0;
         core_a     <= '0;
         core_b     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_ready  <= req_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_gcd    <= rsp_gcd_d;
         core_rst_n <= core_rst_n_d;
         core_a     <= core_a_d;
         core_b     <= core_b_d;
         done_q     <= done_d;
      end
   end

   // Next state and next output values.
   always_comb begin
      state_d   = state_q;
      rsp_gcd_d = rsp_gcd;
      core_a_d  = core_a;
      core_b_d  = core_b;
      done_d    = done_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               core_a_d = req_a;
               core_b_d = req_b;
               if (bypass) begin
                  rsp_gcd_d = bypass_gcd;
                  state_d   = RESP;
               end else begin
                  state_d = RESTART;
               end
            end
         end
         RESTART: begin
            done_d  = 1'b0;
            state_d = WAIT;
         end
         WAIT: begin
            done_d = core_done;
            if (done_rise) begin
               rsp_gcd_d = core_gcd;
               state_d   = RESP;
            end else if (wait_expired) begin
               rsp_gcd_d = '0;
               state_d   = RESP;
            end
         end
         RESP: begin
            if (rsp_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d  = (state_d == IDLE);
      rsp_valid_d  = (state_d == RESP);
      core_rst_n_d = (state_d != RESTART);
   end

endmodule
